// File: rtl/mfcc_frame_rd_agen.sv
// Read-side address generator for the 128-entry MFCC sample ring: start = write pointer - frame length,
// then one address per accepted beat. Define MFCC_RD_REVERSE_EN to emit the frame newest-first.
module mfcc_frame_rd_agen #(
  parameter int ADDR_WIDTH = 7,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [LEN_WIDTH-1:0]  DEPTH = LEN_WIDTH'(1 << ADDR_WIDTH);
  localparam logic [LEN_WIDTH-1:0]  ONE_L = LEN_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  // Carry-chain adder with the final carry-out dropped, giving modulo-2^ADDR_WIDTH results.
  function automatic logic [ADDR_WIDTH-1:0] cla_add(input logic [ADDR_WIDTH-1:0] a,
                                                     input logic [ADDR_WIDTH-1:0] b,
                                                     input logic                  cin);
    logic [ADDR_WIDTH-1:0] s;
    logic                  c;
    s = '0;
    c = cin;
    for (int i = 0; i < ADDR_WIDTH; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
    end
    return s;
  endfunction

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  rd_valid_q;
  logic                  busy_q;
  logic                  done_q;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]  len_q;

  logic [LEN_WIDTH-1:0]  len_eff_d;
  logic [ADDR_WIDTH-1:0] load_addr_d;
  logic [ADDR_WIDTH-1:0] step_addr_d;

  assign len_eff_d = (frame_len > DEPTH) ? DEPTH : frame_len;

`ifdef MFCC_RD_REVERSE_EN
  // Newest sample first: base - 1, then walk downwards.
  assign load_addr_d = cla_add(base_q, {ADDR_WIDTH{1'b1}}, 1'b0);
  assign step_addr_d = rd_addr_q - ONE_A;
`else
  // base + ~len + 1; a full-buffer length has zero low bits and lands back on base.
  assign load_addr_d = cla_add(base_q, ~len_q[ADDR_WIDTH-1:0], 1'b1);
  assign step_addr_d = rd_addr_q + ONE_A;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      base_q     <= '0;
      len_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q  <= base_addr;
            len_q   <= len_eff_d;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          rd_addr_q <= load_addr_d;
          cnt_q     <= len_q;
          if (len_q == '0) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            rd_valid_q <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (rd_valid_q && rd_ready) begin
            rd_addr_q <= step_addr_d;
            cnt_q     <= cnt_q - ONE_L;
            if (cnt_q == ONE_L) begin
              rd_valid_q <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= DONE;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_addr  = rd_addr_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_mfcc_frame_rd_agen.sv
// Directed bench for mfcc_frame_rd_agen: frame-level model checked every cycle, plus literal frame expectations.
module tb_mfcc_frame_rd_agen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] base_addr = '0;
  logic [7:0] frame_len = '0;
  logic [6:0] rd_addr;
  logic       rd_valid;
  logic       rd_ready = 1'b1;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  mfcc_frame_rd_agen #(.ADDR_WIDTH(7), .LEN_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .frame_len(frame_len),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_ready(rd_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame model: a frame of n addresses starting at (base - n) mod 128, offered from T+2,
  // one per accepted beat, done the cycle after the n-th acceptance (T+2 when n is 0).
  int cyc = 0;
  bit m_active = 1'b0;
  int m_T = 0;
  int m_n = 0;
  int m_acc = 0;
  int m_base = 0;
  int m_done_cyc = -1;

  logic       e_valid;
  logic       e_done;
  logic [6:0] e_addr;

  assign e_valid = m_active && (cyc >= m_T + 2) && (m_acc < m_n);
  assign e_done  = m_active && (cyc == m_done_cyc);
`ifdef MFCC_RD_REVERSE_EN
  assign e_addr = 7'(m_base - 1 - m_acc);
`else
  assign e_addr = 7'(m_base - m_n + m_acc);
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (!m_active) begin
        if (start) begin
          m_active   <= 1'b1;
          m_T        <= cyc;
          m_n        <= (int'(frame_len) > 128) ? 128 : int'(frame_len);
          m_acc      <= 0;
          m_base     <= int'(base_addr);
          m_done_cyc <= (frame_len == 8'd0) ? cyc + 2 : -1;
        end
      end else if (cyc == m_done_cyc) begin
        m_active <= 1'b0;
      end else if (e_valid && rd_ready) begin
        m_acc <= m_acc + 1;
        if (m_acc + 1 == m_n) m_done_cyc <= cyc + 1;
      end
    end
  end

  // Per-cycle compare and capture of accepted addresses.
  int got[$];
  int exp_q[$];
  int done_at = -1;
  int valid_seen = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_rd_valid", int'(rd_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_rd_addr", int'(rd_addr), 0);
    end else begin
      chk("busy", int'(busy), int'(m_active));
      chk("rd_valid", int'(rd_valid), int'(e_valid));
      chk("done", int'(done), int'(e_done));
      if (e_valid) chk("rd_addr", int'(rd_addr), int'(e_addr));
      if (rd_valid) valid_seen++;
      if (rd_valid && rd_ready) got.push_back(int'(rd_addr));
      if (done) done_at = cyc;
    end
  end

  int t_start = 0;

  task automatic frame(input int base, input int len, input int stall_a, input int stall_b,
                       input int extra_start);
    got.delete();
    done_at = -1;
    valid_seen = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 7'(base); frame_len = 8'(len); rd_ready = 1'b1;
    @(posedge clk); #1;
    t_start = m_T;
    start = 1'b0; base_addr = 7'($urandom); frame_len = 8'($urandom);
    for (int k = 1; k <= 400; k++) begin
      if (k > 1 && !m_active) return;
      rd_ready = !(k == stall_a || k == stall_b);
      start = (k == extra_start);
      if (k == extra_start) begin
        base_addr = 7'd99; frame_len = 8'd7;
      end
      @(posedge clk); #1;
    end
    chk("frame_timeout", 0, 1);
  endtask

  task automatic expect_frame(input string name, input int done_off);
    int tmp[$];
`ifdef MFCC_RD_REVERSE_EN
    tmp = exp_q;
    exp_q.delete();
    for (int i = tmp.size() - 1; i >= 0; i--) exp_q.push_back(tmp[i]);
`endif
    chk({name, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk({name, "_addr"}, got[i], exp_q[i]);
    chk({name, "_done_off"}, done_at - t_start, done_off);
  endtask

  initial begin
    #1;
    chk("reset_rd_addr", int'(rd_addr), 0);
    chk("reset_rd_valid", int'(rd_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic frame
    frame(10, 4, 0, 0, 0);
    exp_q = '{6, 7, 8, 9};
    expect_frame("basic", 6);
    chk("basic_busy_low_T7", int'(busy), 0);
    chk("basic_idle_offset", cyc - t_start, 7);

    // Wrap through 127 -> 0
    frame(2, 5, 0, 0, 0);
    exp_q = '{125, 126, 127, 0, 1};
    expect_frame("wrap", 7);

    // Full buffer, length saturates to 128
    frame(0, 200, 0, 0, 0);
    exp_q.delete();
    for (int i = 0; i < 128; i++) exp_q.push_back(i);
    expect_frame("full", 130);

    // Backpressure in cycles T+3 and T+4
    frame(20, 3, 3, 4, 0);
    exp_q = '{17, 18, 19};
    expect_frame("bp", 7);

    // Zero length
    frame(33, 0, 0, 0, 0);
    exp_q.delete();
    expect_frame("zero", 2);
    chk("zero_valid_seen", valid_seen, 0);

    // Start pulsed while running must be ignored
    frame(40, 3, 0, 0, 3);
    exp_q = '{37, 38, 39};
    expect_frame("ign_start", 5);
    repeat (3) @(posedge clk);
    #1 chk("ign_start_idle", int'(busy), 0);

    // Asynchronous reset during the second beat of a 10-beat frame
    @(posedge clk); #1;
    start = 1'b1; base_addr = 7'd30; frame_len = 8'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("midrst_beat2_addr", int'(rd_addr), 21);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_rd_addr", int'(rd_addr), 0);
    chk("midrst_rd_valid", int'(rd_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    frame(50, 2, 0, 0, 0);
    exp_q = '{48, 49};
    expect_frame("post_rst", 4);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
